// File: rtl/uart_tx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_if
// Bus bundle between the CPU I/O side / baud generator and the UART
// transmitter.
//
// Signals
//   brg_full    baud tick, one clk wide, one pulse per bit time
//   iocs        chip select
//   iorw        1 = read, 0 = write
//   ioaddr      register address (0 = TX data, 1 = control/clear)
//   databus     write data
//   tbr         FIFO has space
//   tx_idle     FIFO empty and no frame in progress
//   txd         serial output, idles high
//   fifo_count  entries currently queued
//   ovf         sticky overflow flag
//
// Modports
//   master  drives the bus and tick, observes status (CPU / bench side)
//   slave   the transmitter
// ---------------------------------------------------------------------------
interface uart_tx_fifo_if #(
  parameter int FIFO_DEPTH = 4
);
  logic                          brg_full;
  logic                          iocs;
  logic                          iorw;
  logic [1:0]                    ioaddr;
  logic [7:0]                    databus;
  logic                          tbr;
  logic                          tx_idle;
  logic                          txd;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          ovf;

  modport master (
    output brg_full, iocs, iorw, ioaddr, databus,
    input  tbr, tx_idle, txd, fifo_count, ovf
  );

  modport slave (
    input  brg_full, iocs, iorw, ioaddr, databus,
    output tbr, tx_idle, txd, fifo_count, ovf
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// UART transmitter fed by a small write-side FIFO. Software writes characters
// to address 0; frames (start, DATA_BITS data LSB first, optional parity,
// STOP_BITS stop bits) are sent back-to-back on txd, advancing only on the
// shared baud tick brg_full. A write to a full FIFO is dropped and sets the
// sticky ovf flag, which is cleared by writing 1 to bit 0 of address 1.
//
// Parameters
//   DATA_BITS   5..8 data bits per frame
//   FIFO_DEPTH  power of two, 2..16
//   PARITY      0 none, 1 even, 2 odd
//   STOP_BITS   1 or 2
//
// Ports
//   clk   clock, all state on posedge
//   rst   asynchronous active-high reset
//   bus   uart_tx_fifo_if.slave: brg_full/iocs/iorw/ioaddr/databus in,
//         tbr/tx_idle/txd/fifo_count/ovf out (all registered or derived
//         from registers only)
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_fifo_if.slave    bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic          LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  // Parity of a character as it is popped; odd parity is the inverted XOR.
  function automatic logic f_parity(input logic [DATA_BITS-1:0] d);
    logic x;
    x = ^d;
    return (PARITY == 2) ? ~x : x;
  endfunction

  // FIFO storage and control
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [CW-1:0]        r_count;
  logic                 r_ovf;

  // Transmit engine
  logic [2:0]           r_state;
  logic                 r_txd;
  logic [2:0]           r_bit;
  logic                 r_stop;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;

  logic                 w_wr;
  logic                 w_clr;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_last_stop;
  logic                 w_pop;
  logic                 w_push;
  logic [DATA_BITS-1:0] w_head;
  logic [DATA_BITS-1:0] w_wdata;
  logic                 w_shift_en;

  assign w_wr    = bus.iocs & ~bus.iorw & (bus.ioaddr == 2'd0);
  assign w_clr   = bus.iocs & ~bus.iorw & (bus.ioaddr == 2'd1) & bus.databus[0];
  assign w_wdata = bus.databus[DATA_BITS-1:0];

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_C);

  assign w_last_stop = (r_state == S_STOP) & (r_stop == LAST_STOP);

  // A pop only happens where a new start bit is driven: from IDLE or on the
  // final stop tick. Emptiness comes from registered state, so a push in
  // the same cycle as an IDLE tick is only seen at the following tick.
  assign w_pop  = bus.brg_full & ~w_empty & ((r_state == S_IDLE) | w_last_stop);

  // A full FIFO still accepts a write when the head leaves in that cycle;
  // the write slot equals the read slot and the old head is read first.
  assign w_push = w_wr & (~w_full | w_pop);

  assign w_head = r_mem[r_rptr];

  // The START tick emits bit 0, each DATA tick emits the next bit, so the
  // shifter advances on both.
  assign w_shift_en = bus.brg_full & ((r_state == S_START) | (r_state == S_DATA));

  // ---- FIFO storage (data, no reset)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_wdata;
    end
  end

  // ---- FIFO pointers, occupancy and overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      // Pointers wrap naturally because FIFO_DEPTH is a power of two.
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // Set has priority over clear.
      if (w_wr & ~w_push) begin
        r_ovf <= 1'b1;
      end else if (w_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // ---- Character shifter and latched parity (data, no reset)
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_shift <= w_head;
      r_par   <= f_parity(w_head);
    end else if (w_shift_en) begin
      r_shift <= r_shift >> 1;
    end
  end

  // ---- Frame sequencer; txd is registered and moves only on baud ticks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_txd   <= 1'b1;
      r_bit   <= 3'd0;
      r_stop  <= 1'b0;
    end else if (bus.brg_full) begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_txd   <= 1'b0;
            r_state <= S_START;
          end else begin
            r_txd   <= 1'b1;
          end
        end
        S_START: begin
          r_txd   <= r_shift[0];
          r_bit   <= 3'd0;
          r_state <= S_DATA;
        end
        S_DATA: begin
          // r_bit counts data bit-times already on the line after the
          // START tick; the last one hands over to parity or stop.
          if (r_bit == LAST_DATA) begin
            if (PARITY != 0) begin
              r_txd   <= r_par;
              r_state <= S_PAR;
            end else begin
              r_txd   <= 1'b1;
              r_stop  <= 1'b0;
              r_state <= S_STOP;
            end
          end else begin
            r_txd <= r_shift[0];
            r_bit <= r_bit + 3'd1;
          end
        end
        S_PAR: begin
          r_txd   <= 1'b1;
          r_stop  <= 1'b0;
          r_state <= S_STOP;
        end
        S_STOP: begin
          if (r_stop == LAST_STOP) begin
            // Back-to-back: the next start bit replaces the idle bit.
            if (w_pop) begin
              r_txd   <= 1'b0;
              r_state <= S_START;
            end else begin
              r_txd   <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_txd  <= 1'b1;
            r_stop <= r_stop + 1'b1;
          end
        end
        default: begin
          r_txd   <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.tbr        = ~w_full;
  assign bus.tx_idle    = (r_state == S_IDLE) & w_empty;
  assign bus.txd        = r_txd;
  assign bus.fifo_count = r_count;
  assign bus.ovf        = r_ovf;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
// Three transmitters share one stimulus stream:
//   0: 8 data bits, no parity, 1 stop
//   1: 7 data bits, even parity, 2 stops
//   2: 7 data bits, odd parity, 2 stops
// A frame-level reference model (queue of characters plus a "line busy for
// one frame length" counter) predicts occupancy, flags and the txd bit for
// every baud tick. Accepted characters are also pushed to a scoreboard that a
// separate monitor pops when it decodes a complete frame from txd.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int NI    = 3;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       brg_full;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] databus;

  logic       o_txd  [NI];
  logic       o_tbr  [NI];
  logic       o_idle [NI];
  logic       o_ovf  [NI];
  logic [2:0] o_cnt  [NI];

  function automatic int cdb(input int i);
    return (i == 0) ? 8 : 7;
  endfunction

  function automatic int cpar(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 1 : 2);
  endfunction

  function automatic int csb(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic int flen(input int i);
    return 1 + cdb(i) + ((cpar(i) != 0) ? 1 : 0) + csb(i);
  endfunction

  // Bits following the start bit, LSB first: data, parity, stop bits.
  function automatic int frame_word(input int i, input int d);
    int w;
    int pos;
    int p;
    w   = d & ((1 << cdb(i)) - 1);
    pos = cdb(i);
    if (cpar(i) != 0) begin
      p = $countones(w) % 2;
      if (cpar(i) == 2) p = 1 - p;
      w = w | (p << pos);
      pos++;
    end
    for (int s = 0; s < csb(i); s++) begin
      w = w | (1 << pos);
      pos++;
    end
    return w;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int LDB  = (g == 0) ? 8 : 7;
    localparam int LPAR = (g == 0) ? 0 : ((g == 1) ? 1 : 2);
    localparam int LSB  = (g == 0) ? 1 : 2;

    uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

    assign bus.brg_full = brg_full;
    assign bus.iocs     = iocs;
    assign bus.iorw     = iorw;
    assign bus.ioaddr   = ioaddr;
    assign bus.databus  = databus;

    uart_tx_fifo #(
      .DATA_BITS (LDB),
      .FIFO_DEPTH(DEPTH),
      .PARITY    (LPAR),
      .STOP_BITS (LSB)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );

    assign o_txd[g]  = bus.txd;
    assign o_tbr[g]  = bus.tbr;
    assign o_idle[g] = bus.tx_idle;
    assign o_ovf[g]  = bus.ovf;
    assign o_cnt[g]  = bus.fifo_count;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  int mq   [NI][$];   // characters waiting in the FIFO
  int bq   [NI][$];   // bits still to be placed on the line
  int sbq  [NI][$];   // scoreboard: characters the monitor must decode
  int rem  [NI];      // ticks until the line may start another frame
  int m_ovf[NI];
  int m_txd[NI];
  bit ticked;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ticked = 1'b0;
      for (int i = 0; i < NI; i++) begin
        mq[i].delete();
        bq[i].delete();
        sbq[i].delete();
        rem[i]   = 0;
        m_ovf[i] = 0;
        m_txd[i] = 1;
      end
    end else begin
      ticked = brg_full;
      for (int i = 0; i < NI; i++) begin
        if (brg_full) begin
          if (rem[i] > 0) rem[i]--;
          if (rem[i] == 0 && mq[i].size() > 0) begin
            int b;
            int fw;
            b      = mq[i].pop_front();
            rem[i] = flen(i);
            fw     = frame_word(i, b);
            bq[i].push_back(0);
            for (int k = 0; k < flen(i) - 1; k++) bq[i].push_back((fw >> k) & 1);
          end
          m_txd[i] = (bq[i].size() > 0) ? bq[i].pop_front() : 1;
        end
        if (iocs && !iorw && ioaddr == 2'd1 && databus[0]) m_ovf[i] = 0;
        if (iocs && !iorw && ioaddr == 2'd0) begin
          if (mq[i].size() < DEPTH) begin
            int d;
            d = int'(databus) & ((1 << cdb(i)) - 1);
            mq[i].push_back(d);
            sbq[i].push_back(d);
          end else begin
            m_ovf[i] = 1;
          end
        end
      end
    end
  end

  // ---------------- monitor / checker ----------------
  int n_tot  = 0;
  int n_pass = 0;
  bit done    = 1'b0;
  bit timeout = 1'b0;
  int dcnt[NI];
  int dval[NI];

  task automatic chk(input string nm, input int i, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s inst%0d: got %0d, expected %0d (t=%0t)", nm, i, act, exp, $time);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      chk("fifo_count", i, int'(o_cnt[i]), mq[i].size());
      chk("tbr", i, int'(o_tbr[i]), (mq[i].size() != DEPTH) ? 1 : 0);
      chk("tx_idle", i, int'(o_idle[i]), (rem[i] == 0 && mq[i].size() == 0) ? 1 : 0);
      chk("ovf", i, int'(o_ovf[i]), m_ovf[i]);
      chk("txd", i, int'(o_txd[i]), m_txd[i]);
      if (rst) begin
        dcnt[i] = 0;
        dval[i] = 0;
      end else if (ticked) begin
        if (dcnt[i] == 0) begin
          if (o_txd[i] == 1'b0) begin
            dcnt[i] = 1;
            dval[i] = 0;
          end
        end else begin
          dval[i] = dval[i] | (int'(o_txd[i]) << (dcnt[i] - 1));
          if (dcnt[i] == flen(i) - 1) begin
            dcnt[i] = 0;
            if (sbq[i].size() == 0) chk("frame_unexpected", i, dval[i], -1);
            else chk("frame", i, dval[i], frame_word(i, sbq[i].pop_front()));
          end else begin
            dcnt[i]++;
          end
        end
      end
    end
    if (done) begin
      for (int i = 0; i < NI; i++) chk("frames_left", i, sbq[i].size(), 0);
      chk("drain_timeout", 0, int'(timeout), 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic b, input logic cs, input logic rw,
                      input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    brg_full = b;
    iocs     = cs;
    iorw     = rw;
    ioaddr   = a;
    databus  = d;
  endtask

  task automatic run(input int n, input int per);
    for (int k = 0; k < n; k++) step(((k % per) == per - 1), 1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    step(1'b0, 1'b1, 1'b0, a, d);
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < NI; i++)
      if (mq[i].size() != 0 || rem[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain();
    for (int k = 0; k < 4000 && !all_idle(); k++)
      step(((k % 4) == 3), 1'b0, 1'b0, 2'd0, 8'h00);
    if (!all_idle()) timeout = 1'b1;
    run(4, 4);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; brg_full = 1'b0; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'd0; databus = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run(4, 4);

    // Reset pulsed between edges with a character queued.
    wr(2'd0, 8'h3C);
    async_reset();
    run(4, 4);

    // Single frames at a 16-clock bit time.
    wr(2'd0, 8'hA5);
    run(16 * 14, 16);
    wr(2'd0, 8'h35);
    run(16 * 14, 16);

    // Fill with no baud ticks, overflow, clear, then transmit in order.
    for (int k = 1; k <= 5; k++) wr(2'd0, 8'(k));
    run(3, 1000);
    wr(2'd1, 8'h01);
    run(3, 1000);
    drain();

    // Back-to-back characters.
    wr(2'd0, 8'h55);
    wr(2'd0, 8'hAA);
    run(16 * 30, 16);

    // Reset in the middle of the data bits, then a clean frame with
    // ignored bus traffic while it is sent.
    wr(2'd0, 8'hC3);
    run(4 * 5 + 1, 4);
    async_reset();
    run(4, 4);
    wr(2'd0, 8'h0F);
    step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 2'd0, 8'hFF);
    step(1'b1, 1'b1, 1'b0, 2'd2, 8'h77);
    step(1'b0, 1'b1, 1'b0, 2'd3, 8'h01);
    step(1'b1, 1'b1, 1'b1, 2'd1, 8'h01);
    drain();

    // Randomised traffic: mixed addresses, reads, clears and overflow.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 2) == 0)
        step(((k % 3) == 2), 1'b1, 1'($urandom_range(0, 3) == 0),
             2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      else
        step(((k % 3) == 2), 1'b0, 1'b0, 2'd0, 8'h00);
    end
    drain();

    done = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with a write-side FIFO, configurable frame format (data width, parity, stop bits) and an overflow flag. It sits between the CPU I/O bus (iocs/iorw/ioaddr/databus) and the serial txd pin, driven by the shared baud-rate generator tick `brg_full`. It lets software queue several characters and sends frames back-to-back with no idle gap.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal range 5..8. Uses `databus[DATA_BITS-1:0]`.
- `FIFO_DEPTH`, default 4: FIFO entries; power of two, 2..16.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: 1 or 2.
- `clk`  in  1  sole clock; all state changes on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `brg_full`  in  1  baud tick; one `clk` wide; one pulse per bit time.
- `iocs`  in  1  chip select.
- `iorw`  in  1  1 = read, 0 = write.
- `ioaddr`  in  2  register address.
- `databus`  in  8  write data.
- `tbr`  out  1  FIFO not full (space available).
- `tx_idle`  out  1  FIFO empty and no frame in progress.
- `txd`  out  1  serial output; idles high.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  entries currently queued.
- `ovf`  out  1  sticky overflow flag.

## Operation
- Push strobe: `wr = iocs & ~iorw & (ioaddr == 2'd0)`.
  - If the FIFO is not full, or a pop occurs in the same cycle, push `databus[DATA_BITS-1:0]`.
  - Otherwise drop the byte and set `ovf`.
- Clear strobe: `iocs & ~iorw & (ioaddr == 2'd1) & databus[0]` clears `ovf`. If a clear and an overflow coincide, set wins.
- Reads and all other addresses are ignored.
- FSM states: IDLE, START, DATA, PAR, STOP. All transitions happen only on cycles with `brg_full` = 1.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, compute parity, set `txd` = 0 and go to START. Otherwise hold `txd` = 1.
  - START: send `txd` = bit0 and go to DATA with bit index 0.
  - DATA: bits go out LSB first. After DATA_BITS bit-times, go to PAR if PARITY != 0, else STOP, driving the parity bit or `txd` = 1 respectively.
  - PAR: send `txd` = 1 and go to STOP.
  - STOP: lasts STOP_BITS bit-times. At its final tick:
    - if the FIFO is non-empty, pop and drive `txd` = 0, going to START (back-to-back, no idle bit);
    - otherwise go to IDLE.
- Parity:
  - even: XOR of the DATA_BITS data bits;
  - odd: the inverse of that XOR;
  - latched at pop.
- Frame length is 1 + DATA_BITS + (PARITY != 0) + STOP_BITS bit-times.
- `fifo_count` behaviour:
  - push only: +1;
  - pop only: −1;
  - push and pop together: unchanged;
  - read and write pointers wrap modulo FIFO_DEPTH.
- `tbr = (fifo_count != FIFO_DEPTH)`.
- `tx_idle = (state == IDLE) & (fifo_count == 0)`.
- Reset at any time, including mid-frame, immediately sets:
  - `txd` = 1, state = IDLE;
  - FIFO empty, `fifo_count` = 0;
  - `ovf` = 0, `tbr` = 1, `tx_idle` = 1.
  - A partial frame is abandoned, not completed.

## Timing
- `txd` is registered and changes one clk after the qualifying `brg_full` edge.
- A push is visible in `fifo_count` and `tbr` on the next clk.
- A push and an IDLE `brg_full` in the same cycle: no pop that cycle, because empty is evaluated on registered state. The frame starts at the next `brg_full`.
- The FIFO head is popped on the same edge that drives the start bit.
- `ovf` sets on the clk after the dropped write.
- Outputs are never combinational from bus inputs.

## Test plan
- Reset, with `rst` pulsed asynchronously between edges → `txd`=1, `tbr`=1, `tx_idle`=1, `fifo_count`=0, `ovf`=0 immediately.
- Default params, write 0xA5, `brg_full` every 16 clk → `txd` per bit: 0,1,0,1,0,0,1,0,1,1; `tx_idle` returns to 1 after the stop tick.
- DATA_BITS=7, PARITY=1, STOP_BITS=2, write 0x35 → `txd`: 0,1,0,1,0,1,1,0,0,1,1. With PARITY=2 the parity bit is 1.
- FIFO_DEPTH=4, `brg_full` held 0, five writes 0x01..0x05:
  - `fifo_count`=4 and `tbr`=0 after the 4th write;
  - the 5th is dropped and `ovf`=1;
  - a write to ioaddr 1 with databus=0x01 → `ovf`=0;
  - enabling `brg_full` then transmits 0x01..0x04 in order.
- Back-to-back: write 0x55 and 0xAA → the second start bit immediately follows the first stop bit with no extra high bit time; `fifo_count` goes 2→1→0 at each start.
- Reset asserted during data bit 3 → `txd`=1 at once and FIFO emptied; a subsequent write of 0x0F transmits a correct full frame.
  - Reads (`iorw`=1) and writes to ioaddr 2/3 during the frame have no effect.
